// File: rtl/tone_divider.sv
// Runtime-programmable square-wave divider for the organ tone path.
// Define TONE_DIV_ODD_EN for exact odd divisors (high half rounds up).
module tone_divider #(
  parameter int W       = 24,
  parameter int RST_DIV = 4
) (
  input  logic         I_CLK,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_valid,
  output logic         div_ready,
  output logic         O_CLK,
  output logic         O_TICK,
  output logic [W-1:0] cur_div
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  localparam logic [W-1:0] RST_DIV_L = W'(RST_DIV);
  localparam logic [W-1:0] DIV_MIN   = W'(2);
  localparam logic [W-1:0] ONE       = W'(1);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic [W-1:0] cur_q, cur_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pv_q, pv_d;

  logic [W-1:0] hh;
  logic [W-1:0] hl;
  logic [W-1:0] div_clamp;
  logic         accept;
  logic         apply;

`ifdef TONE_DIV_ODD_EN
  // Odd divisors: the extra cycle goes to the high half.
  logic [W:0] cur_p1;
  assign cur_p1 = {1'b0, cur_q} + {{W{1'b0}}, 1'b1};
  assign hh     = cur_p1[W:1];
  assign hl     = cur_q >> 1;
`else
  // Even-only: the divisor LSB is dropped.
  assign hh = cur_q >> 1;
  assign hl = cur_q >> 1;
`endif

  assign div_clamp = (div_in < DIV_MIN) ? DIV_MIN : div_in;
  assign accept    = div_valid & ~pv_q;

  // Phase sequencing, boundary-aligned divisor update and handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    cur_d   = cur_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    apply   = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_d = 1'b0;
        cnt_d = '0;
        apply = pv_q;
        if (en) begin
          state_d = HIGH;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      HIGH: begin
        if (!en) begin
          state_d = IDLE;
          clk_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == hh - ONE) begin
          state_d = LOW;
          clk_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      LOW: begin
        if (!en) begin
          state_d = IDLE;
          clk_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == hl - ONE) begin
          apply   = pv_q;
          state_d = HIGH;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        clk_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
    if (apply) begin
      cur_d = pend_q;
      pv_d  = 1'b0;
    end
    if (accept) begin
      pend_d = div_clamp;
      pv_d   = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge I_CLK) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      cur_q   <= RST_DIV_L;
      pend_q  <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
    end
  end

  assign div_ready = ~pv_q;
  assign O_CLK     = clk_q;
  assign O_TICK    = tick_q;
  assign cur_div   = cur_q;

endmodule

// File: tb/tb_tone_divider.sv
// Directed bench for tone_divider; expectations follow TONE_DIV_ODD_EN.
module tb_tone_divider;

  localparam int W = 24;

  logic         I_CLK;
  logic         rst;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_valid;
  logic         div_ready;
  logic         O_CLK;
  logic         O_TICK;
  logic [W-1:0] cur_div;

  int checks;
  int errors;

  logic [15:0] cv;
  logic [15:0] tv;
  logic [15:0] rv;

  tone_divider #(.W(W), .RST_DIV(4)) dut (
    .I_CLK     (I_CLK),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .O_CLK     (O_CLK),
    .O_TICK    (O_TICK),
    .cur_div   (cur_div)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge I_CLK);
      #1;
    end
  endtask

  // Samples n cycles; bit i holds sample i.
  task automatic collect(input int n, output logic [15:0] c,
                         output logic [15:0] t, output logic [15:0] r);
    c = '0;
    t = '0;
    r = '0;
    for (int i = 0; i < n; i++) begin
      c[i] = O_CLK;
      t[i] = O_TICK;
      r[i] = div_ready;
      step(1);
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 64; i++) begin
      if (O_TICK) break;
      step(1);
    end
    chk("wait_tick", 32'(O_TICK), 32'd1);
  endtask

  task automatic load(input logic [W-1:0] d);
    div_in    = d;
    div_valid = 1'b1;
    step(1);
    div_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    en        = 1'b0;
    div_in    = '0;
    div_valid = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_clk", 32'(O_CLK), 32'd0);
    chk("rst_tick", 32'(O_TICK), 32'd0);
    chk("rst_cur", 32'(cur_div), 32'd4);
    chk("rst_rdy", 32'(div_ready), 32'd1);

    en = 1'b1;
    step(1);
    collect(8, cv, tv, rv);
    chk("div4_clk", 32'(cv), 32'h33);
    chk("div4_tick", 32'(tv), 32'h11);

    load(24'd10);
    chk("d10_rdy0", 32'(div_ready), 32'd0);
    chk("d10_cur_old", 32'(cur_div), 32'd4);
    collect(13, cv, tv, rv);
    chk("d10_clk", 32'(cv), 32'h00F9);
    chk("d10_tick", 32'(tv), 32'h0008);
    chk("d10_rdy", 32'(rv), 32'h1FF8);
    chk("d10_cur", 32'(cur_div), 32'd10);

    load(24'd6);
    div_in    = 24'd8;
    div_valid = 1'b1;
    step(1);
    div_valid = 1'b0;
    chk("d6_rdy0", 32'(div_ready), 32'd0);
    chk("d6_cur_old", 32'(cur_div), 32'd10);
    wait_tick();
    chk("d6_cur", 32'(cur_div), 32'd6);
    collect(12, cv, tv, rv);
    chk("d6_clk", 32'(cv), 32'h01C7);

    load(24'd0);
    chk("d0_rdy0", 32'(div_ready), 32'd0);
    wait_tick();
    chk("d0_cur", 32'(cur_div), 32'd2);
    collect(8, cv, tv, rv);
    chk("d2_clk", 32'(cv), 32'h55);
    chk("d2_tick", 32'(tv), 32'h55);

    load(24'd8);
    wait_tick();
    chk("d8_cur", 32'(cur_div), 32'd8);
    step(5);
    chk("d8_low", 32'(O_CLK), 32'd0);
    en = 1'b0;
    step(1);
    collect(3, cv, tv, rv);
    chk("stop_clk", 32'(cv), 32'h0);
    chk("stop_tick", 32'(tv), 32'h0);
    load(24'd12);
    chk("idle_cur_old", 32'(cur_div), 32'd8);
    chk("idle_rdy0", 32'(div_ready), 32'd0);
    step(1);
    chk("idle_cur", 32'(cur_div), 32'd12);
    chk("idle_rdy1", 32'(div_ready), 32'd1);
    en = 1'b1;
    step(1);
    collect(13, cv, tv, rv);
    chk("d12_clk", 32'(cv), 32'h103F);
    chk("d12_tick", 32'(tv), 32'h1001);

    load(24'd10);
    wait_tick();
    chk("r_cur10", 32'(cur_div), 32'd10);
    step(2);
    load(24'd6);
    chk("r_pend", 32'(div_ready), 32'd0);
    chk("r_high", 32'(O_CLK), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("r_clk", 32'(O_CLK), 32'd0);
    chk("r_tick", 32'(O_TICK), 32'd0);
    chk("r_cur", 32'(cur_div), 32'd4);
    chk("r_rdy", 32'(div_ready), 32'd1);
    step(1);
    collect(8, cv, tv, rv);
    chk("r_run_clk", 32'(cv), 32'h33);
    chk("r_run_cur", 32'(cur_div), 32'd4);

    load(24'd5);
    wait_tick();
    chk("d5_cur", 32'(cur_div), 32'd5);
    collect(10, cv, tv, rv);
`ifdef TONE_DIV_ODD_EN
    chk("d5_clk", 32'(cv), 32'h00E7);
`else
    chk("d5_clk", 32'(cv), 32'h0333);
`endif

    load(24'd3);
    wait_tick();
    chk("d3_cur", 32'(cur_div), 32'd3);
    collect(6, cv, tv, rv);
`ifdef TONE_DIV_ODD_EN
    chk("d3_clk", 32'(cv), 32'h1B);
    chk("d3_tick", 32'(tv), 32'h09);
`else
    chk("d3_clk", 32'(cv), 32'h15);
    chk("d3_tick", 32'(tv), 32'h15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
